// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int ARB_WIDTH = 32;
    localparam int ARB_OPW   = 4;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the requester not granted last.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_t    last_grant_i,
    output req_id_t    grant_o,
    output logic       grant_any_o
);

    always_comb begin
        grant_o = 1'b0;
        if (valid_i[0] && valid_i[1]) begin
            grant_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
    end

    assign grant_any_o = |valid_i;

endmodule

// File: rtl/alu_arb_2x1.sv
// Round-robin arbiter/sequencer for a shared ALU, one transaction in flight.
// Optional watchdog on the ALU wait enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arb_2x1
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = ARB_WIDTH,
    parameter int OPW     = ARB_OPW,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    req_id_t          last_grant_q;
    req_id_t          grant;
    logic             grant_any;
    logic             accept;
    logic             timeout;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_data_q;
    logic [OPW-1:0]   alu_op_q;
    req_id_t          rsp_id_q;

    alu_arb_rr u_rr (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_any_o  (grant_any)
    );

    // Gating with rst_n keeps both readys low while reset is asserted.
    assign accept = rst_n && (state_q == IDLE) && grant_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_done || timeout) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_start  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = accept && (grant == 1'b0);
                req1_ready = accept && (grant == 1'b1);
            end
            ISSUE:   alu_start = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            if (accept) begin
                alu_a_q      <= grant ? req1_a  : req0_a;
                alu_b_q      <= grant ? req1_b  : req0_b;
                alu_op_q     <= grant ? req1_op : req0_op;
                rsp_id_q     <= grant;
                last_grant_q <= grant;
            end
            if (state_q == WAIT && alu_done) begin
                rsp_data_q <= alu_result;
            end else if (timeout) begin
                rsp_data_q <= '0;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_err_q;

    // A done in the final WAIT cycle still wins over the watchdog.
    assign timeout = (state_q == WAIT) && !alu_done
                     && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
            if (state_q == WAIT && (alu_done || timeout)) begin
                rsp_err_q <= timeout;
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;

endmodule
